run_pattern_tx: RTL

- Serial stimulus transmitter for the run-length sequence-detector FSM, on the transmit side of its `w` input.
- Takes (bit value, run length) commands over a valid/ready handshake and serializes them onto a one-bit stream, one bit per clock.
- Alongside each bit it drives `exp_z`: the two-bit output the detector must produce after sampling that bit.
- Used in self-checking benches and on-board BIST to drive the detector and score its `z` output.

---
 rtl/run_pattern_pkg.sv | 14 +
 rtl/run_pattern_tx_tracker.sv | 60 ++++++
 rtl/run_pattern_tx.sv | 102 ++++++++++
 3 files changed

// File: rtl/run_pattern_pkg.sv
// Shared constants for the run-length pattern transmitter and its run tracker.
package run_pattern_pkg;

    localparam int unsigned DETECT_N_DEF = 4;

    // Handshake FSM encodings
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    // exp_z bit indices
    localparam int unsigned Z_ZERO_RUN = 0;
    localparam int unsigned Z_ONE_RUN  = 1;

endpackage

// File: rtl/run_pattern_tx_tracker.sv
// Tracks the current run of equal serial bits and predicts the detector's z output.
module run_tracker
    import run_pattern_pkg::*;
#(
    parameter int unsigned DETECT_N = DETECT_N_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_valid,
    input  logic       in_bit,
    output logic [1:0] exp_z
);

    localparam int unsigned CNT_W = $clog2(DETECT_N + 1);

    logic             prev_bit_q, prev_bit_d;
    logic             hist_valid_q, hist_valid_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [1:0]       exp_z_q, exp_z_d;
    logic             hit;

    // History is frozen whenever no bit is sent
    always_comb begin
        prev_bit_d   = prev_bit_q;
        hist_valid_d = hist_valid_q;
        run_cnt_d    = run_cnt_q;
        exp_z_d      = exp_z_q;
        hit          = 1'b0;
        if (bit_valid) begin
            if (hist_valid_q && (in_bit == prev_bit_q)) begin
                run_cnt_d = (run_cnt_q >= CNT_W'(DETECT_N)) ? CNT_W'(DETECT_N)
                                                            : CNT_W'(run_cnt_q + 1'b1);
            end else begin
                run_cnt_d = CNT_W'(1);
            end
            prev_bit_d   = in_bit;
            hist_valid_d = 1'b1;
            hit          = (run_cnt_d >= CNT_W'(DETECT_N));
            exp_z_d[Z_ZERO_RUN] = hit && !in_bit;
            exp_z_d[Z_ONE_RUN]  = hit && in_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_bit_q   <= 1'b0;
            hist_valid_q <= 1'b0;
            run_cnt_q    <= '0;
            exp_z_q      <= 2'b00;
        end else begin
            prev_bit_q   <= prev_bit_d;
            hist_valid_q <= hist_valid_d;
            run_cnt_q    <= run_cnt_d;
            exp_z_q      <= exp_z_d;
        end
    end

    assign exp_z = exp_z_q;

endmodule

// File: rtl/run_pattern_tx.sv
// Serializes (bit, length) commands onto w, one bit per clock, with the expected detector output.
module run_pattern_tx
    import run_pattern_pkg::*;
#(
    parameter int unsigned LEN_W    = 4,
    parameter int unsigned DETECT_N = DETECT_N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_bit,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             w,
    output logic             w_valid,
    output logic             last,
    output logic [1:0]       exp_z,
    output logic             busy
);

    logic [0:0]       state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             w_q, w_d;
    logic             w_valid_q, w_valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             accept;

    // Ready in IDLE, or on the final bit so a new command can follow with no bubble
    assign cmd_ready = !rst && ((state_q == IDLE) || last_q);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        w_d         = w_q;
        case (state_q)
            IDLE: begin
                if (accept && (cmd_len != '0)) begin
                    state_d     = SEND;
                    remaining_d = cmd_len;
                    w_d         = cmd_bit;
                end
            end
            SEND: begin
                if (last_q) begin
                    if (accept && (cmd_len != '0)) begin
                        remaining_d = cmd_len;
                        w_d         = cmd_bit;
                    end else begin
                        state_d     = IDLE;
                        remaining_d = '0;
                    end
                end else begin
                    remaining_d = LEN_W'(remaining_q - 1'b1);
                end
            end
            default: begin
                state_d     = IDLE;
                remaining_d = '0;
            end
        endcase
        w_valid_d = (state_d == SEND);
        busy_d    = (state_d == SEND);
        last_d    = (state_d == SEND) && (remaining_d == LEN_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            w_q         <= 1'b0;
            w_valid_q   <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            w_q         <= w_d;
            w_valid_q   <= w_valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
        end
    end

    // Fed with next-cycle values so exp_z lines up with the w it describes
    run_tracker #(
        .DETECT_N (DETECT_N)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (w_valid_d),
        .in_bit    (w_d),
        .exp_z     (exp_z)
    );

    assign w       = w_q;
    assign w_valid = w_valid_q;
    assign last    = last_q;
    assign busy    = busy_q;

endmodule
